// File: rtl/des_pkg.sv
// Shared DES constants: PC-1/PC-2 tables, shift schedule, key-schedule state type.
// Also provides the PC-1 expansion and the 28-bit half rotations used by the schedule.
package des_pkg;

  localparam int DES_KEY_W    = 56;
  localparam int DES_SUBKEY_W = 48;
  localparam int DES_HALF_W   = 28;
  localparam int DES_ROUNDS   = 16;

  typedef enum logic {
    KS_IDLE,
    KS_EMIT
  } des_ks_state_t;

  // Table entries are FIPS bit numbers, 1 = MSB of the source vector.
  localparam int DES_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int DES_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int DES_SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Parity bits are re-inserted as zeros; PC-1 never selects them.
  function automatic logic [DES_KEY_W-1:0] des_pc1(input logic [DES_KEY_W-1:0] key);
    logic [63:0]          key64;
    logic [DES_KEY_W-1:0] cd;
    for (int i = 0; i < 8; i++) begin
      key64[63-8*i -: 8] = {key[DES_KEY_W-1-7*i -: 7], 1'b0};
    end
    for (int i = 0; i < DES_KEY_W; i++) begin
      cd[DES_KEY_W-1-i] = key64[64-DES_PC1[i]];
    end
    return cd;
  endfunction

  function automatic logic [DES_HALF_W-1:0] des_rotl(input logic [DES_HALF_W-1:0] x,
                                                     input logic two);
    return two ? {x[DES_HALF_W-3:0], x[DES_HALF_W-1 -: 2]}
               : {x[DES_HALF_W-2:0], x[DES_HALF_W-1]};
  endfunction

  function automatic logic [DES_HALF_W-1:0] des_rotr(input logic [DES_HALF_W-1:0] x,
                                                     input logic two);
    return two ? {x[1:0], x[DES_HALF_W-1:2]}
               : {x[0], x[DES_HALF_W-1:1]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// DES permuted choice 2: selects 48 of the 56 C||D bits to form a round subkey.
// Pure wiring; shared with any future unrolled key schedule.
module des_pc2
  import des_pkg::*;
(
  input  logic [DES_KEY_W-1:0]    cd,
  output logic [DES_SUBKEY_W-1:0] subkey
);

  logic unused_dropped;

  always_comb begin
    subkey = '0;
    for (int i = 0; i < DES_SUBKEY_W; i++) begin
      subkey[DES_SUBKEY_W-1-i] = cd[DES_KEY_W-DES_PC2[i]];
    end
  end

  // FIPS bits 9,18,22,25,35,38,43,54 are the ones PC-2 discards.
  assign unused_dropped = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: streams K1..K16 (encrypt) or K16..K1 (decrypt), one per handshake.
// Optional weak-key flag is built only when DES_KEY_WEAK_CHECK_EN is defined.
module des_key_schedule
  import des_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    e,
  input  logic [DES_KEY_W-1:0]    key,
  input  logic                    sk_ready,
  output logic [DES_SUBKEY_W-1:0] subkey,
  output logic                    sk_valid,
  output logic [3:0]              round,
  output logic                    busy,
  output logic                    done,
  output logic                    weak_key
);

  des_ks_state_t         state_q, state_d;
  logic [DES_HALF_W-1:0] c_q, c_d, d_q, d_d;
  logic                  dir_q, dir_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [DES_KEY_W-1:0]  cd0;
  logic [DES_HALF_W-1:0] c0, d0;
  logic                  start_acc, handshake, two;
  logic [3:0]            enc_idx, dec_idx;

  assign cd0       = des_pc1(key);
  assign c0        = cd0[DES_KEY_W-1:DES_HALF_W];
  assign d0        = cd0[DES_HALF_W-1:0];
  assign start_acc = start & ~busy_q;
  assign handshake = (state_q == KS_EMIT) & sk_ready;
  assign enc_idx   = cnt_q + 4'd1;
  assign dec_idx   = 4'd15 - cnt_q;
  assign two       = dir_q ? (DES_SHIFTS[enc_idx] == 2) : (DES_SHIFTS[dec_idx] == 2);

  // busy stays high through the done cycle so a start there is ignored.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (start_acc) begin
      state_d = KS_EMIT;
      dir_d   = e;
      cnt_d   = 4'd0;
      busy_d  = 1'b1;
      c_d     = e ? des_rotl(c0, 1'b0) : c0;
      d_d     = e ? des_rotl(d0, 1'b0) : d0;
    end else if (handshake) begin
      if (cnt_q == 4'd15) begin
        state_d = KS_IDLE;
        cnt_d   = 4'd0;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
        c_d   = dir_q ? des_rotl(c_q, two) : des_rotr(c_q, two);
        d_d   = dir_q ? des_rotl(d_q, two) : des_rotr(d_q, two);
      end
    end else if (done_q) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= KS_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      dir_q   <= 1'b1;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  des_pc2 u_pc2 (
    .cd     ({c_q, d_q}),
    .subkey (subkey)
  );

  assign sk_valid = (state_q == KS_EMIT);
  assign round    = dir_q ? cnt_q : 4'd15 - cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef DES_KEY_WEAK_CHECK_EN
  logic weak_q, weak_d;

  // Weak keys are exactly those whose halves are each all-zeros or all-ones.
  always_comb begin
    weak_d = weak_q;
    if (start_acc) begin
      weak_d = ((c0 == '0) || (c0 == '1)) && ((d0 == '0) || (d0 == '1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      weak_q <= 1'b0;
    end else begin
      weak_q <= weak_d;
    end
  end

  assign weak_key = weak_q;
`else
  assign weak_key = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: a from-scratch subkey model plus FIPS literal vectors.
// Honours DES_KEY_WEAK_CHECK_EN when choosing the expected weak_key value.
module tb_des_key_schedule;

  localparam logic [55:0] FIPS_KEY  = 56'h12695BC9B7B7F8;
  localparam logic [55:0] OTHER_KEY = 56'h0123456789ABCD;
  localparam logic [47:0] FIPS_K1   = 48'h1B02EFFC7072;
  localparam logic [47:0] FIPS_K16  = 48'hCB3D8B0E17F5;

`ifdef DES_KEY_WEAK_CHECK_EN
  localparam bit WEAK_EN = 1'b1;
`else
  localparam bit WEAK_EN = 1'b0;
`endif

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        e = 1'b0;
  logic [55:0] key = '0;
  logic        sk_ready = 1'b1;
  logic [47:0] subkey;
  logic        sk_valid;
  logic [3:0]  round;
  logic        busy;
  logic        done;
  logic        weak_key;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  des_key_schedule dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .e        (e),
    .key      (key),
    .sk_ready (sk_ready),
    .subkey   (subkey),
    .sk_valid (sk_valid),
    .round    (round),
    .busy     (busy),
    .done     (done),
    .weak_key (weak_key)
  );

  always #5 clk = ~clk;

  // C0||D0 straight from the FIPS description: 64-bit key with zero parity, then PC-1.
  function automatic logic [55:0] model_cd0(input logic [55:0] k);
    logic [63:0] k64;
    logic [55:0] cd;
    for (int b = 1; b <= 64; b++) begin
      k64[64-b] = (b % 8 == 0) ? 1'b0 : k[56-(b - b/8)];
    end
    for (int i = 0; i < 56; i++) cd[55-i] = k64[64-PC1[i]];
    return cd;
  endfunction

  // Subkey K(r+1) via the cumulative rotation amount rather than step by step.
  function automatic logic [47:0] model_subkey(input logic [55:0] k, input int r);
    logic [55:0] cd, cc, dd, cdr;
    logic [47:0] sk;
    int tot;
    cd  = model_cd0(k);
    tot = 0;
    for (int i = 0; i <= r; i++) tot += SH[i];
    tot = tot % 28;
    cc  = {cd[55:28], cd[55:28]} << tot;
    dd  = {cd[27:0], cd[27:0]} << tot;
    cdr = {cc[55:28], dd[55:28]};
    for (int j = 0; j < 48; j++) sk[47-j] = cdr[56-PC2[j]];
    return sk;
  endfunction

  function automatic logic model_weak(input logic [55:0] k);
    logic [55:0] cd;
    cd = model_cd0(k);
    return ((cd[55:28] == '0) || (cd[55:28] == '1)) && ((cd[27:0] == '0) || (cd[27:0] == '1));
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural model of the handshake protocol, updated on the same edge as the DUT.
  logic        m_valid = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_weak = 1'b0;
  logic        m_dir = 1'b1;
  logic [3:0]  m_cnt = 4'd0;
  logic [55:0] m_key = '0;
  logic [3:0]  m_round;
  logic [47:0] seen [512];
  int          seen_n = 0;

  assign m_round = m_dir ? m_cnt : 4'd15 - m_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_weak  <= 1'b0;
      m_cnt   <= 4'd0;
    end else begin
      m_done <= 1'b0;
      if (m_valid && sk_ready) begin
        if (m_cnt == 4'd15) begin
          m_valid <= 1'b0;
          m_done  <= 1'b1;
        end else begin
          m_cnt <= m_cnt + 4'd1;
        end
      end else if (start && !m_busy) begin
        m_key   <= key;
        m_dir   <= e;
        m_cnt   <= 4'd0;
        m_valid <= 1'b1;
        m_busy  <= 1'b1;
        m_weak  <= WEAK_EN ? model_weak(key) : 1'b0;
      end else if (m_done) begin
        m_busy <= 1'b0;
      end
      if (sk_valid && sk_ready && seen_n < 512) begin
        seen[seen_n] <= subkey;
        seen_n       <= seen_n + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("sk_valid", 64'(sk_valid), 64'(m_valid));
      checkOutput("busy", 64'(busy), 64'(m_busy));
      checkOutput("done", 64'(done), 64'(m_done));
      checkOutput("weak_key", 64'(weak_key), 64'(m_weak));
      if (m_valid) begin
        checkOutput("round", 64'(round), 64'(m_round));
        checkOutput("subkey", 64'(subkey), 64'(model_subkey(m_key, int'(m_round))));
      end
    end
  end

  // Returns on the negedge of the first cycle after start is presented.
  task automatic applyStimulus(input logic [55:0] k, input logic dir);
    @(negedge clk);
    key   = k;
    e     = dir;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int  base;
    bit  got_done;

    // Reset values
    rst_n = 1'b0;
    waitCycles(2);
    checkOutput("rst_subkey", 64'(subkey), 64'h0);
    checkOutput("rst_sk_valid", 64'(sk_valid), 64'h0);
    checkOutput("rst_round", 64'(round), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_done", 64'(done), 64'h0);
    checkOutput("rst_weak", 64'(weak_key), 64'h0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    checkOutput("model_k1", 64'(model_subkey(FIPS_KEY, 0)), 64'(FIPS_K1));
    checkOutput("model_k16", 64'(model_subkey(FIPS_KEY, 15)), 64'(FIPS_K16));

    // Encrypt FIPS vector, full throughput, then a start in the done cycle
    sk_ready = 1'b1;
    applyStimulus(FIPS_KEY, 1'b1);
    checkOutput("enc_c1_subkey", 64'(subkey), 64'(FIPS_K1));
    checkOutput("enc_c1_round", 64'(round), 64'd0);
    waitCycles(15);
    checkOutput("enc_c16_subkey", 64'(subkey), 64'(FIPS_K16));
    checkOutput("enc_c16_round", 64'(round), 64'd15);
    waitCycles(1);
    checkOutput("enc_c17_done", 64'(done), 64'd1);
    checkOutput("enc_c17_busy", 64'(busy), 64'd1);
    key   = OTHER_KEY;
    e     = 1'b0;
    start = 1'b1;
    waitCycles(1);
    start = 1'b0;
    checkOutput("done_cycle_start_valid", 64'(sk_valid), 64'd0);
    checkOutput("done_cycle_start_busy", 64'(busy), 64'd0);

    // Decrypt FIPS vector
    applyStimulus(FIPS_KEY, 1'b0);
    checkOutput("dec_c1_subkey", 64'(subkey), 64'(FIPS_K16));
    checkOutput("dec_c1_round", 64'(round), 64'd15);
    waitCycles(15);
    checkOutput("dec_c16_subkey", 64'(subkey), 64'(FIPS_K1));
    checkOutput("dec_c16_round", 64'(round), 64'd0);
    waitCycles(2);

    // Random backpressure on an encrypt schedule
    base     = seen_n;
    got_done = 1'b0;
    sk_ready = 1'b0;
    applyStimulus(FIPS_KEY, 1'b1);
    for (int c = 0; c < 400 && !got_done; c++) begin
      sk_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    checkOutput("bp_done_seen", 64'(got_done), 64'd1);
    checkOutput("bp_count", 64'(seen_n - base), 64'd16);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("bp_k%0d", i + 1), 64'(seen[base+i]), 64'(model_subkey(FIPS_KEY, i)));
    end
    sk_ready = 1'b1;
    waitCycles(2);

    // start while busy at cnt=3 is ignored
    applyStimulus(FIPS_KEY, 1'b1);
    waitCycles(3);
    checkOutput("busy_start_round3", 64'(round), 64'd3);
    key   = OTHER_KEY;
    e     = 1'b0;
    start = 1'b1;
    waitCycles(1);
    start = 1'b0;
    checkOutput("busy_start_round4", 64'(round), 64'd4);
    checkOutput("busy_start_k5", 64'(subkey), 64'(model_subkey(FIPS_KEY, 4)));
    waitCycles(11);
    checkOutput("busy_start_k16", 64'(subkey), 64'(FIPS_K16));
    waitCycles(2);

    // Reset mid-schedule at cnt=7
    applyStimulus(FIPS_KEY, 1'b1);
    waitCycles(7);
    checkOutput("midrst_round7", 64'(round), 64'd7);
    rst_n = 1'b0;
    waitCycles(1);
    rst_n = 1'b1;
    checkOutput("midrst_subkey", 64'(subkey), 64'h0);
    checkOutput("midrst_valid", 64'(sk_valid), 64'h0);
    checkOutput("midrst_round", 64'(round), 64'h0);
    checkOutput("midrst_busy", 64'(busy), 64'h0);
    checkOutput("midrst_done", 64'(done), 64'h0);
    checkOutput("midrst_weak", 64'(weak_key), 64'h0);
    applyStimulus(FIPS_KEY, 1'b1);
    checkOutput("midrst_restart_k1", 64'(subkey), 64'(FIPS_K1));
    waitCycles(17);

    // Weak-key flag
    applyStimulus(56'h0, 1'b1);
    checkOutput("weak_zero", 64'(weak_key), WEAK_EN ? 64'd1 : 64'd0);
    waitCycles(17);
    applyStimulus(56'hFFFFFFFFFFFFFF, 1'b1);
    checkOutput("weak_ones", 64'(weak_key), WEAK_EN ? 64'd1 : 64'd0);
    waitCycles(17);
    applyStimulus(FIPS_KEY, 1'b1);
    checkOutput("weak_fips", 64'(weak_key), 64'd0);
    waitCycles(17);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
